// File: rtl/w0rm_core_writeback.sv
// W0RM writeback stage: merges ALU results (priority) and FIFO-buffered load results into one
// register-file write per cycle, and tracks outstanding loads. Optional macro: W0RM_WB_BYPASS_EN.
module w0rm_core_writeback #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 16,
  parameter int FIFO_DEPTH    = 4,
  localparam int RA = $clog2(NUM_REGISTERS)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  input  logic                     alu_write_i,
  input  logic [RA-1:0]            alu_dest_i,
  input  logic [DATA_WIDTH-1:0]    alu_data_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [RA-1:0]            mem_dest_i,
  input  logic [DATA_WIDTH-1:0]    mem_data_i,
  input  logic                     issue_load_i,
  input  logic [RA-1:0]            issue_dest_i,
  output logic [NUM_REGISTERS-1:0] pending_mask_o,
  output logic [RA-1:0]            port_write_addr_o,
  output logic                     port_write_enable_o,
  output logic [DATA_WIDTH-1:0]    port_write_data_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NR = NUM_REGISTERS;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [RA-1:0]         fifo_dest_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [RA-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NR-1:0]         pend_q, pend_d, clr_mask, set_mask;
  logic                  alu_acc, fifo_empty, push, pop, bypass;

  always_comb begin
    alu_acc    = alu_valid_i & alu_write_i & ~flush_i;
    fifo_empty = (count_q == '0);
    pop        = ~fifo_empty & ~alu_acc;
`ifdef W0RM_WB_BYPASS_EN
    // An idle stage lets a load skip the FIFO entirely.
    bypass     = mem_valid_i & fifo_empty & ~alu_acc;
`else
    bypass     = 1'b0;
`endif
    push       = mem_valid_i & ready_q & ~bypass;
    count_d    = count_q + CW'(push) - CW'(pop);
    ready_d    = (count_d != CW'(FIFO_DEPTH));

    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    clr_mask = '0;
    if (alu_acc) begin
      we_d   = 1'b1;
      addr_d = alu_dest_i;
      data_d = alu_data_i;
    end else if (pop) begin
      we_d     = 1'b1;
      addr_d   = fifo_dest_q[rd_ptr_q];
      data_d   = fifo_data_q[rd_ptr_q];
      clr_mask = NR'(1) << fifo_dest_q[rd_ptr_q];
    end else if (bypass) begin
      we_d     = 1'b1;
      addr_d   = mem_dest_i;
      data_d   = mem_data_i;
      clr_mask = NR'(1) << mem_dest_i;
    end

    // A fresh issue to the same register outranks the retiring one.
    set_mask = issue_load_i ? (NR'(1) << issue_dest_i) : '0;
    pend_d   = (pend_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pend_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_data_i;
      fifo_dest_q[wr_ptr_q] <= mem_dest_i;
    end
  end

  assign mem_ready_o         = ready_q;
  assign pending_mask_o      = pend_q;
  assign port_write_enable_o = we_q;
  assign port_write_addr_o   = addr_q;
  assign port_write_data_o   = data_q;
endmodule

// File: tb/tb_w0rm_core_writeback.sv
// Self-checking bench for w0rm_core_writeback: a per-cycle reference model pushes expected
// outputs to a scoreboard queue; they are popped and compared after each clock edge.
module tb_w0rm_core_writeback;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int RA = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, flush, alu_valid, alu_write, mem_valid, issue_load;
  logic [RA-1:0] alu_dest, mem_dest, issue_dest;
  logic [DW-1:0] alu_data, mem_data;
  logic          mem_ready, wen;
  logic [NR-1:0] pending_mask;
  logic [RA-1:0] waddr;
  logic [DW-1:0] wdata;

  w0rm_core_writeback #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .alu_valid_i(alu_valid), .alu_write_i(alu_write), .alu_dest_i(alu_dest), .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_dest_i(mem_dest), .mem_data_i(mem_data),
    .issue_load_i(issue_load), .issue_dest_i(issue_dest), .pending_mask_o(pending_mask),
    .port_write_addr_o(waddr), .port_write_enable_o(wen), .port_write_data_o(wdata)
  );

  typedef struct packed {logic [RA-1:0] d; logic [DW-1:0] v;} ld_t;
  typedef struct packed {
    logic en; logic [RA-1:0] a; logic [DW-1:0] d; logic [NR-1:0] pm; logic rdy;
  } exp_t;

  ld_t  stim_q[$];
  ld_t  mq[$];
  exp_t exp_q[$];
  logic          m_rdy, m_en;
  logic [RA-1:0] m_a;
  logic [DW-1:0] m_d;
  logic [NR-1:0] m_pm;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_rdy = 1'b1; m_en = 1'b0; m_a = '0; m_d = '0; m_pm = '0;
    mq.delete(); stim_q.delete(); exp_q.delete();
  endtask

  task automatic load(input logic [RA-1:0] d, input logic [DW-1:0] v);
    ld_t e;
    e.d = d; e.v = v;
    stim_q.push_back(e);
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cyc(input bit av, input bit aw, input bit fl, input logic [RA-1:0] ad,
                     input logic [DW-1:0] adat, input bit il, input logic [RA-1:0] idst);
    bit acc, push, pop, byp;
    ld_t head;
    exp_t e, got;
    logic [NR-1:0] clr;
    alu_valid = av; alu_write = aw; flush = fl; alu_dest = ad; alu_data = adat;
    issue_load = il; issue_dest = idst;
    mem_valid = (stim_q.size() > 0);
    mem_dest = mem_valid ? stim_q[0].d : '0;
    mem_data = mem_valid ? stim_q[0].v : '0;

    acc  = av && aw && !fl;
    push = mem_valid && m_rdy;
    byp  = 1'b0;
`ifdef W0RM_WB_BYPASS_EN
    byp = push && (mq.size() == 0) && !acc;
    if (byp) push = 1'b0;
`endif
    pop = (mq.size() > 0) && !acc;
    clr = '0;
    if (acc) begin
      m_en = 1'b1; m_a = ad; m_d = adat;
    end else if (pop) begin
      head = mq[0];
      m_en = 1'b1; m_a = head.d; m_d = head.v; clr[head.d] = 1'b1;
    end else if (byp) begin
      m_en = 1'b1; m_a = mem_dest; m_d = mem_data; clr[mem_dest] = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    m_pm = m_pm & ~clr;
    if (il) m_pm[idst] = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(stim_q[0]);
    m_rdy = (mq.size() != DEPTH);
    e.en = m_en; e.a = m_a; e.d = m_d; e.pm = m_pm; e.rdy = m_rdy;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (push || byp) void'(stim_q.pop_front());
    got = exp_q.pop_front();
    check("wen", 64'(wen), 64'(got.en));
    check("waddr", 64'(waddr), 64'(got.a));
    check("wdata", 64'(wdata), 64'(got.d));
    check("pending", 64'(pending_mask), 64'(got.pm));
    check("ready", 64'(mem_ready), 64'(got.rdy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    // Reset with every input active.
    reset_n = 1'b0; flush = 1'b1; alu_valid = 1'b1; alu_write = 1'b1; alu_dest = 4'hF;
    alu_data = '1; mem_valid = 1'b1; mem_dest = 4'hF; mem_data = '1; issue_load = 1'b1;
    issue_dest = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 64'(wen), 64'(0));
    check("rst_pending", 64'(pending_mask), 64'(0));
    check("rst_waddr", 64'(waddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    flush = 0; alu_valid = 0; alu_write = 0; mem_valid = 0; issue_load = 0;
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_ready", 64'(mem_ready), 64'(1));

    // ALU only: latency 1, single-cycle strobe.
    cyc(1, 1, 0, 4'd3, 32'hDEADBEEF, 0, '0);
    check("alu_en", 64'(wen), 64'(1));
    check("alu_addr", 64'(waddr), 64'(3));
    check("alu_data", 64'(wdata), 64'hDEADBEEF);
    idle(1);
    check("alu_en_off", 64'(wen), 64'(0));
    check("alu_hold", 64'(wdata), 64'hDEADBEEF);
    cyc(1, 0, 0, 4'd5, 32'h1111, 0, '0);

    // Contention: ALU busy for 6 cycles, 5 loads arrive.
    for (int i = 0; i < 5; i++) load(RA'(i + 8), 32'hA000 + DW'(i));
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0, RA'(i), 32'hC000 + DW'(i), 0, '0);
      if (i == 3) check("full_ready", 64'(mem_ready), 64'(0));
    end
    idle(8);

    // Scoreboard: set by issue, cleared by retire, re-issue at retire edge wins.
    cyc(0, 0, 0, '0, '0, 1, 4'd7);
    check("sb7_set", 64'(pending_mask[7]), 64'(1));
    load(4'd7, 32'h55);
`ifdef W0RM_WB_BYPASS_EN
    cyc(0, 0, 0, '0, '0, 1, 4'd7);
`else
    idle(1);
    check("sb7_wait", 64'(pending_mask[7]), 64'(1));
    cyc(0, 0, 0, '0, '0, 1, 4'd7);
`endif
    check("sb7_keep", 64'(pending_mask[7]), 64'(1));
    check("sb7_data", 64'(wdata), 64'h55);
    idle(2);

    // Flush while two loads wait in the FIFO.
    load(4'd10, 32'hF10); load(4'd11, 32'hF11);
    cyc(1, 1, 0, 4'd1, 32'hB1, 0, '0);
    cyc(1, 1, 0, 4'd2, 32'hB2, 0, '0);
    cyc(1, 1, 1, 4'd4, 32'hBAD, 0, '0);
    check("flush_addr", 64'(waddr), 64'(10));
    idle(1);
    check("flush_addr2", 64'(waddr), 64'(11));
    idle(2);

    // Load latency from an empty FIFO.
    load(4'd2, 32'hA5A5);
    idle(1);
`ifdef W0RM_WB_BYPASS_EN
    check("lat_en", 64'(wen), 64'(1));
    check("lat_addr", 64'(waddr), 64'(2));
`else
    check("lat_en0", 64'(wen), 64'(0));
    idle(1);
    check("lat_en", 64'(wen), 64'(1));
    check("lat_addr", 64'(waddr), 64'(2));
`endif
    idle(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if (stim_q.size() < 3 && $urandom_range(2) == 0)
        load(RA'($urandom_range(15)), DW'($urandom));
      cyc(bit'($urandom_range(1)), bit'($urandom_range(3) != 0), bit'($urandom_range(5) == 0),
          RA'($urandom_range(15)), DW'($urandom), bit'($urandom_range(3) == 0),
          RA'($urandom_range(15)));
    end
    idle(10);

    // Reset mid-operation drops queued loads and pending bits immediately.
    load(4'd6, 32'h66); load(4'd9, 32'h99);
    cyc(1, 1, 0, 4'd1, 32'h1, 1, 4'd6);
    cyc(1, 1, 0, 4'd1, 32'h2, 1, 4'd9);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_pend", 64'(pending_mask), 64'(0));
    check("mid_rst_wen", 64'(wen), 64'(0));
    mem_valid = 0; alu_valid = 0; issue_load = 0; flush = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    idle(3);
    check("mid_rst_ready", 64'(mem_ready), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
